gpc1406_accum: RTL

- Streaming consumer placed directly downstream of a gpc1406_5 compressor.
- Each accepted beat presents one 1406 bit-heap slice:
  - 6 bits of weight 1
  - 4 bits of weight 4
  - 1 bit of weight 8
- An internal gpc1406_5 reduces each beat to a 5-bit partial sum (max 30). The block registers it and accumulates it over a packet of beats.
- It emits one saturated packet total plus a beat count per packet, with valid/ready handshakes on both sides.

---
 rtl/gpc_pkg.sv | 24 ++
 rtl/gpc1406_5.sv | 27 ++
 rtl/gpc1406_accum.sv | 137 +++++++++++++
 3 files changed

// File: rtl/gpc_pkg.sv
// Shared constants and the saturating adder used by the 1406 counter accumulator.
package gpc_pkg;

    localparam int GPC1406_IN0 = 6;
    localparam int GPC1406_IN2 = 4;
    localparam int GPC1406_IN3 = 1;
    localparam int GPC1406_OUT = 5;

    // Bit 32 of the result is the saturation flag, bits [31:0] the clamped sum.
    function automatic logic [32:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned acc_w);
        logic [32:0] full;
        logic [32:0] max_v;
        full  = {1'b0, a} + {1'b0, b};
        max_v = (33'd1 << acc_w) - 33'd1;
        if (full > max_v) begin
            sat_add = {1'b1, max_v[31:0]};
        end else begin
            sat_add = {1'b0, full[31:0]};
        end
    endfunction

endpackage

// File: rtl/gpc1406_5.sv
// Combinational (1,4,0,6;5) generalized parallel counter: popcounts weighted 1, 4 and 8.
module gpc1406_5
    import gpc_pkg::*;
(
    input  logic [GPC1406_IN0-1:0] src0,
    input  logic [GPC1406_IN2-1:0] src2,
    input  logic [GPC1406_IN3-1:0] src3,
    output logic [GPC1406_OUT-1:0] dst
);

    logic [2:0] pop0;
    logic [2:0] pop2;

    // Weighted popcount of the bit-heap slice.
    always_comb begin
        pop0 = 3'd0;
        pop2 = 3'd0;
        for (int i = 0; i < GPC1406_IN0; i++) begin
            pop0 = pop0 + {2'b00, src0[i]};
        end
        for (int i = 0; i < GPC1406_IN2; i++) begin
            pop2 = pop2 + {2'b00, src2[i]};
        end
        dst = {2'b00, pop0} + {pop2, 2'b00} + {1'b0, src3, 3'b000};
    end

endmodule

// File: rtl/gpc1406_accum.sv
// Packet accumulator behind a gpc1406_5: one registered partial-sum stage, then a
// saturating per-packet sum/count emitted through a valid/ready output register.
module gpc1406_accum
    import gpc_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [5:0]       src0,
    input  logic [3:0]       src2,
    input  logic [0:0]       src3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    logic [GPC1406_OUT-1:0] gpc_dst;
    logic [GPC1406_OUT-1:0] s1_dst_q, s1_dst_d;
    logic                   s1_last_q, s1_last_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   out_valid_q, out_valid_d;
    logic [ACC_W-1:0]       out_sum_q, out_sum_d;
    logic [CNT_W-1:0]       out_count_q, out_count_d;
    logic                   out_ovf_q, out_ovf_d;
    logic                   s1_adv;
    logic                   in_fire;
    logic                   sat_term;
    logic [32:0]            sum_full;
    logic [32:0]            cnt_full;
    logic                   unused_full_bits;

    gpc1406_5 u_gpc (
        .src0 (src0),
        .src2 (src2),
        .src3 (src3),
        .dst  (gpc_dst)
    );

    // A last beat may only leave S1 when the output register is free or draining.
    assign s1_adv   = s1_valid_q & (~s1_last_q | ~out_valid_q | out_ready);
    assign in_ready = ~rst & (~s1_valid_q | s1_adv);
    assign in_fire  = in_valid & in_ready;

    assign sum_full = sat_add(32'(acc_q), 32'(s1_dst_q), ACC_W);
    assign cnt_full = sat_add(32'(cnt_q), 32'd1, CNT_W);
    assign sat_term = sum_full[32] | cnt_full[32];
    assign unused_full_bits = ^{sum_full, cnt_full};

    // Next-state for the S1 slice, the running accumulator and the output register.
    always_comb begin
        s1_dst_d    = s1_dst_q;
        s1_last_d   = s1_last_q;
        s1_valid_d  = s1_valid_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (in_fire) begin
            s1_dst_d   = gpc_dst;
            s1_last_d  = in_last;
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (s1_adv && s1_last_q) begin
            out_sum_d   = sum_full[ACC_W-1:0];
            out_count_d = cnt_full[CNT_W-1:0];
            out_ovf_d   = ovf_q | sat_term;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
        end else if (s1_adv) begin
            acc_d = sum_full[ACC_W-1:0];
            cnt_d = cnt_full[CNT_W-1:0];
            ovf_d = ovf_q | sat_term;
        end else begin
            acc_d = acc_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_dst_q    <= '0;
            s1_last_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_dst_q    <= s1_dst_d;
            s1_last_q   <= s1_last_d;
            s1_valid_q  <= s1_valid_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule
